// File: rtl/ball_motion_engine.sv
// Per-ball motion engine: fixed-point position/velocity, shot charging (cue ball only),
// per-frame integration with opposing friction, guarded reflections and pocket/respawn.
module ball_motion_engine #(
  parameter int BALL_ID        = 0,
  parameter int INITIAL_X      = 400,
  parameter int INITIAL_Y      = 220,
  parameter int PARK_X         = 600,
  parameter int PARK_Y         = 460,
  parameter int FRAC_BITS      = 6,
  parameter int SPEED_W        = 16,
  parameter int MAX_SHOT_SPEED = 800,
  parameter int SPEED_STEP     = 200,
  parameter int FRICTION_STEP  = 1,
  parameter int MIN_SPEED      = 2,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic                       newGame,
  input  logic                       chargeUp,
  input  logic                       chargeDown,
  input  logic                       chargeLeft,
  input  logic                       chargeRight,
  input  logic                       releaseBall,
  input  logic                       collision_with_ball,
  input  logic [3:0]                 HitEdgeCode,
  input  logic                       collision_with_wall,
  input  logic [3:0]                 wallEdge,
  input  logic                       collision_with_hole,
  output logic signed [10:0]         topLeftX,
  output logic signed [10:0]         topLeftY,
  output logic signed [SPEED_W-1:0]  XspeedOUT,
  output logic signed [SPEED_W-1:0]  YspeedOUT,
  output logic signed [SPEED_W-1:0]  shotX,
  output logic signed [SPEED_W-1:0]  shotY,
  output logic                       moving,
  output logic                       pocketed
);

  localparam int POS_W = 11 + FRAC_BITS;
  localparam int CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES + 1) : 1;

  localparam logic signed [POS_W-1:0]   INIT_X_FP = POS_W'(INITIAL_X * (2 ** FRAC_BITS));
  localparam logic signed [POS_W-1:0]   INIT_Y_FP = POS_W'(INITIAL_Y * (2 ** FRAC_BITS));
  localparam logic signed [POS_W-1:0]   PARK_X_FP = POS_W'(PARK_X * (2 ** FRAC_BITS));
  localparam logic signed [POS_W-1:0]   PARK_Y_FP = POS_W'(PARK_Y * (2 ** FRAC_BITS));
  localparam logic signed [SPEED_W-1:0] STEP_S    = SPEED_W'(SPEED_STEP);
  localparam logic signed [SPEED_W-1:0] MAX_S     = SPEED_W'(MAX_SHOT_SPEED);
  localparam logic signed [SPEED_W-1:0] FSTEP_S   = SPEED_W'(FRICTION_STEP);
  localparam logic signed [SPEED_W-1:0] MIN_S     = SPEED_W'(MIN_SPEED);
  localparam logic [CNT_W-1:0]          CNT_LAST  = CNT_W'(RESPAWN_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, ROLLING, POCKETED} state_t;

  state_t                     state, state_nxt;
  logic signed [POS_W-1:0]    pos_x, pos_y, pos_x_nxt, pos_y_nxt;
  logic signed [SPEED_W-1:0]  vx, vy, vx_nxt, vy_nxt, vx_ref, vy_ref;
  logic signed [SPEED_W-1:0]  fx, fy, fx_nxt, fy_nxt;
  logic signed [SPEED_W-1:0]  sx, sy, sx_nxt, sy_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic                       contact;

  function automatic logic signed [SPEED_W-1:0] abs_s(input logic signed [SPEED_W-1:0] v);
    return (v < 0) ? -v : v;
  endfunction

  // Negate only when moving into the contacted side, so a held contact cannot flip back.
  function automatic logic signed [SPEED_W-1:0] reflect(input logic signed [SPEED_W-1:0] v,
                                                         input logic neg_side,
                                                         input logic pos_side);
    if ((neg_side && v < 0) || (pos_side && v > 0)) return -v;
    return v;
  endfunction

  function automatic logic signed [SPEED_W-1:0] apply_friction(input logic signed [SPEED_W-1:0] v,
                                                                input logic signed [SPEED_W-1:0] f);
    logic signed [SPEED_W-1:0] mag;
    mag = abs_s(v);
    if (mag > MIN_S && (mag - f) > 0) return (v > 0) ? v - f : v + f;
    return '0;
  endfunction

  function automatic logic signed [SPEED_W-1:0] charge(input logic signed [SPEED_W-1:0] shot,
                                                       input logic plus, input logic minus);
    logic signed [SPEED_W-1:0] d, t;
    d = '0;
    if (plus && !minus) d = STEP_S;
    else if (minus && !plus) d = -STEP_S;
    t = shot + d;
    if (abs_s(t) > MAX_S) return shot;
    return t;
  endfunction

  assign contact = collision_with_ball | collision_with_wall;
  assign vx_ref  = reflect(vx, HitEdgeCode[3] | wallEdge[3], HitEdgeCode[1] | wallEdge[1]);
  assign vy_ref  = reflect(vy, HitEdgeCode[2] | wallEdge[2], HitEdgeCode[0] | wallEdge[0]);

  always_comb begin
    state_nxt = state;
    pos_x_nxt = pos_x;
    pos_y_nxt = pos_y;
    vx_nxt    = vx;
    vy_nxt    = vy;
    fx_nxt    = fx;
    fy_nxt    = fy;
    sx_nxt    = sx;
    sy_nxt    = sy;
    cnt_nxt   = cnt;
    if (newGame) begin
      state_nxt = IDLE;
      pos_x_nxt = INIT_X_FP;
      pos_y_nxt = INIT_Y_FP;
      vx_nxt = '0; vy_nxt = '0; fx_nxt = '0; fy_nxt = '0;
      sx_nxt = '0; sy_nxt = '0; cnt_nxt = '0;
    end else if (collision_with_hole && state != POCKETED) begin
      state_nxt = POCKETED;
      pos_x_nxt = PARK_X_FP;
      pos_y_nxt = PARK_Y_FP;
      vx_nxt = '0; vy_nxt = '0; fx_nxt = '0; fy_nxt = '0;
      sx_nxt = '0; sy_nxt = '0; cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (releaseBall && (sx != 0 || sy != 0)) begin
            vx_nxt    = sx;
            vy_nxt    = sy;
            fx_nxt    = (abs_s(sx) / STEP_S) * FSTEP_S;
            fy_nxt    = (abs_s(sy) / STEP_S) * FSTEP_S;
            sx_nxt    = '0;
            sy_nxt    = '0;
            state_nxt = ROLLING;
          end else if (BALL_ID == 0) begin
            sx_nxt = charge(sx, chargeRight, chargeLeft);
            sy_nxt = charge(sy, chargeDown, chargeUp);
          end
        end
        ROLLING: begin
          vx_nxt = vx_ref;
          vy_nxt = vy_ref;
          // Integrate with the pre-update speed; friction is skipped on contact frames.
          if (startOfFrame) begin
            pos_x_nxt = pos_x + POS_W'(vx);
            pos_y_nxt = pos_y + POS_W'(vy);
            if (!contact) begin
              vx_nxt = apply_friction(vx_ref, fx);
              vy_nxt = apply_friction(vy_ref, fy);
            end
          end
          if (vx_nxt == 0 && vy_nxt == 0) begin
            state_nxt = IDLE;
            fx_nxt    = '0;
            fy_nxt    = '0;
          end
        end
        POCKETED: begin
          if (startOfFrame && BALL_ID == 0) begin
            if (cnt == CNT_LAST) begin
              state_nxt = IDLE;
              pos_x_nxt = INIT_X_FP;
              pos_y_nxt = INIT_Y_FP;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      pos_x    <= INIT_X_FP;
      pos_y    <= INIT_Y_FP;
      vx       <= '0;
      vy       <= '0;
      fx       <= '0;
      fy       <= '0;
      sx       <= '0;
      sy       <= '0;
      cnt      <= '0;
      moving   <= 1'b0;
      pocketed <= 1'b0;
    end else begin
      state    <= state_nxt;
      pos_x    <= pos_x_nxt;
      pos_y    <= pos_y_nxt;
      vx       <= vx_nxt;
      vy       <= vy_nxt;
      fx       <= fx_nxt;
      fy       <= fy_nxt;
      sx       <= sx_nxt;
      sy       <= sy_nxt;
      cnt      <= cnt_nxt;
      moving   <= (state_nxt == ROLLING);
      pocketed <= (state_nxt == POCKETED);
    end
  end

  assign topLeftX  = pos_x[POS_W-1:FRAC_BITS];
  assign topLeftY  = pos_y[POS_W-1:FRAC_BITS];
  assign XspeedOUT = vx;
  assign YspeedOUT = vy;
  assign shotX     = sx;
  assign shotY     = sy;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine: a cue-ball instance and an object-ball instance
// share all stimulus; expected values are hand-computed constants.
module tb_ball_motion_engine;

  logic clk = 1'b0;
  logic resetN, startOfFrame, newGame;
  logic chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall;
  logic collision_with_ball, collision_with_wall, collision_with_hole;
  logic [3:0] HitEdgeCode, wallEdge;

  logic signed [10:0] c_x, c_y, o_x, o_y;
  logic signed [15:0] c_vx, c_vy, c_sx, c_sy, o_vx, o_vy, o_sx, o_sy;
  logic c_mov, c_pock, o_mov, o_pock;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ball_motion_engine dut_cue (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .newGame(newGame),
    .chargeUp(chargeUp), .chargeDown(chargeDown), .chargeLeft(chargeLeft),
    .chargeRight(chargeRight), .releaseBall(releaseBall),
    .collision_with_ball(collision_with_ball), .HitEdgeCode(HitEdgeCode),
    .collision_with_wall(collision_with_wall), .wallEdge(wallEdge),
    .collision_with_hole(collision_with_hole),
    .topLeftX(c_x), .topLeftY(c_y), .XspeedOUT(c_vx), .YspeedOUT(c_vy),
    .shotX(c_sx), .shotY(c_sy), .moving(c_mov), .pocketed(c_pock));

  ball_motion_engine #(.BALL_ID(3)) dut_obj (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .newGame(newGame),
    .chargeUp(chargeUp), .chargeDown(chargeDown), .chargeLeft(chargeLeft),
    .chargeRight(chargeRight), .releaseBall(releaseBall),
    .collision_with_ball(collision_with_ball), .HitEdgeCode(HitEdgeCode),
    .collision_with_wall(collision_with_wall), .wallEdge(wallEdge),
    .collision_with_hole(collision_with_hole),
    .topLeftX(o_x), .topLeftY(o_y), .XspeedOUT(o_vx), .YspeedOUT(o_vy),
    .shotX(o_sx), .shotY(o_sy), .moving(o_mov), .pocketed(o_pock));

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    startOfFrame = 0; newGame = 0; chargeUp = 0; chargeDown = 0;
    chargeLeft = 0; chargeRight = 0; releaseBall = 0;
    collision_with_ball = 0; collision_with_wall = 0; collision_with_hole = 0;
    HitEdgeCode = 4'b0000; wallEdge = 4'b0000;
  endtask

  task automatic frame();
    startOfFrame = 1; tick(); startOfFrame = 0; tick();
  endtask

  task automatic game_restart();
    newGame = 1; tick(); newGame = 0; tick();
  endtask

  task automatic wall_hit(input logic [3:0] edges, input logic with_frame);
    collision_with_wall = 1; wallEdge = edges; startOfFrame = with_frame;
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    resetN = 0;
    tick(); tick();
    check("rst_x", c_x, 400);
    check("rst_y", c_y, 220);
    check("rst_vx", c_vx, 0);
    check("rst_vy", c_vy, 0);
    check("rst_moving", c_mov, 0);
    check("rst_pocketed", c_pock, 0);
    check("rst_obj_x", o_x, 400);
    resetN = 1;
    tick();

    // Charge limit
    for (int i = 0; i < 5; i++) begin
      chargeRight = 1; tick(); chargeRight = 0; tick();
      if (i == 3) check("shot_4th", c_sx, 800);
    end
    check("shot_5th_ignored", c_sx, 800);
    check("obj_shot_zero", o_sx, 0);
    chargeLeft = 1; tick(); chargeLeft = 0;
    check("shot_left", c_sx, 600);
    chargeLeft = 1; chargeRight = 1; tick(); chargeLeft = 0; chargeRight = 0;
    check("shot_cancel", c_sx, 600);
    chargeUp = 1; tick(); chargeUp = 0;
    check("shot_up", c_sy, -200);

    // Zero-charge release is a no-op
    game_restart();
    check("ng_shot", c_sx, 0);
    releaseBall = 1; tick(); releaseBall = 0;
    check("rel_zero_moving", c_mov, 0);

    // Single-step shot rolls to a stop
    chargeRight = 1; tick(); chargeRight = 0;
    releaseBall = 1; tick(); releaseBall = 0;
    check("rel_vx", c_vx, 200);
    check("rel_moving", c_mov, 1);
    check("rel_shot_clr", c_sx, 0);
    check("rel_x_static", c_x, 400);
    check("obj_rel_vx", o_vx, 0);
    check("obj_rel_moving", o_mov, 0);
    frame();
    check("f1_x", c_x, 403);
    check("f1_vx", c_vx, 199);
    for (int i = 2; i <= 198; i++) frame();
    check("f198_vx", c_vx, 2);
    check("f198_moving", c_mov, 1);
    startOfFrame = 1; tick(); startOfFrame = 0;
    check("f199_vx", c_vx, 0);
    check("f199_x", c_x, 714);
    check("f199_moving", c_mov, 0);
    check("f199_y", c_y, 220);

    // Reflections at Xspeed = 150 (200 after 50 friction frames)
    game_restart();
    chargeRight = 1; tick(); chargeRight = 0;
    releaseBall = 1; tick(); releaseBall = 0;
    for (int i = 0; i < 50; i++) frame();
    check("r_vx150", c_vx, 150);
    check("r_x537", c_x, 537);
    wall_hit(4'b0010, 1'b0);
    check("r_right", c_vx, -150);
    wall_hit(4'b0010, 1'b0);
    check("r_right_again", c_vx, -150);
    wall_hit(4'b1000, 1'b0);
    check("r_left", c_vx, 150);
    collision_with_ball = 1; HitEdgeCode = 4'b0010;
    collision_with_wall = 1; wallEdge = 4'b0010;
    tick(); clear_inputs();
    check("r_single_neg", c_vx, -150);
    wall_hit(4'b1000, 1'b1);
    check("r_frame_x", c_x, 534);
    check("r_frame_vx", c_vx, 150);

    // Pocket and respawn
    collision_with_hole = 1; tick(); collision_with_hole = 0;
    check("h_pocketed", c_pock, 1);
    check("h_park_x", c_x, 600);
    check("h_park_y", c_y, 460);
    check("h_vx", c_vx, 0);
    check("h_moving", c_mov, 0);
    check("h_obj_pocketed", o_pock, 1);
    for (int i = 0; i < 59; i++) frame();
    check("h59_pocketed", c_pock, 1);
    check("h59_x", c_x, 600);
    frame();
    check("h60_pocketed", c_pock, 0);
    check("h60_x", c_x, 400);
    check("h60_y", c_y, 220);
    check("h60_moving", c_mov, 0);
    check("h60_obj_pocketed", o_pock, 1);
    check("h60_obj_x", o_x, 600);
    game_restart();
    check("ng_obj_pocketed", o_pock, 0);
    check("ng_obj_y", o_y, 220);

    // Asynchronous reset mid-flight
    chargeDown = 1; tick(); chargeDown = 0;
    releaseBall = 1; tick(); releaseBall = 0;
    frame();
    check("ar_vy", c_vy, 199);
    #2 resetN = 0;
    #1;
    check("ar_moving", c_mov, 0);
    check("ar_y", c_y, 220);
    resetN = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
